// File: rtl/pusch_ctrl_pkg.sv
// Shared definitions for the PUSCH slot sequencer.
//   sched_state_t : scheduler FSM state encoding
//   NUM_SYM       : symbols per slot (normal CP)
//   MAX_SYM_IDX   : highest legal symbol index in a slot
//   cfg_legal()   : slot configuration sanity check used at start
package pusch_ctrl_pkg;

    localparam int NUM_SYM     = 14;
    localparam int MAX_SYM_IDX = 13;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DMRS_WAIT  = 3'd1,
        ST_SYM_DECIDE = 3'd2,
        ST_DATA_WAIT  = 3'd3,
        ST_FFT_WAIT   = 3'd4,
        ST_BANK_WAIT  = 3'd5,
        ST_REM_WAIT   = 3'd6,
        ST_DONE       = 3'd7
    } sched_state_t;

    // A slot must cover a non-empty, in-range symbol window and carry at least one RB.
    function automatic logic cfg_legal(input logic [3:0] sym_start,
                                       input logic [3:0] sym_end,
                                       input logic [6:0] n_rb);
        return (sym_start <= sym_end) && (sym_end <= 4'(MAX_SYM_IDX)) && (n_rb != 7'd0);
    endfunction

endpackage

// File: rtl/pusch_wdog.sv
// Wait-state watchdog for the PUSCH scheduler.
//   clk, reset : clock and asynchronous active-low reset
//   clear      : restart the count (the FSM changes state)
//   enable     : count this cycle (FSM is in a wait state)
//   expired    : combinational; high in the TIMEOUT_CYC-th consecutive enabled cycle
module pusch_wdog #(
    parameter int TIMEOUT_CYC = 8192,
    parameter int TO_W        = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= cnt_reg + TO_W'(1);
        end
    end

    // cnt_reg holds the number of wait cycles already completed in this state,
    // so the last allowed cycle is the one where it equals TIMEOUT_CYC-1.
    // Expiry forces a state change, which clears the counter before it can wrap.
    assign expired = enable && (cnt_reg == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pusch_symbol_scheduler.sv
// Slot-level sequencer for the PUSCH back end (DMRS gen -> FFT -> REM -> IFFT/CP).
// Walks symbols sym_start..sym_end, issuing start pulses and waiting on done
// handshakes so only one symbol occupies the shared REM/IFFT path at a time.
//   inputs : clk, reset (async, active-low), start, abort, sym_start, sym_end,
//            dmrs_mask, n_rb, dmrs_done, mod_done, fft_done, rem_done, bank_free
//   outputs: dmrs_start, fft_start, rem_start, bank_valid, slot_done, err (pulses),
//            rem_is_dmrs, rem_bank, sym_idx, busy (levels); all registered
module pusch_symbol_scheduler
    import pusch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 8192,
    parameter int TO_W        = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         sym_start,
    input  logic [3:0]         sym_end,
    input  logic [NUM_SYM-1:0] dmrs_mask,
    input  logic [6:0]         n_rb,
    input  logic               dmrs_done,
    input  logic               mod_done,
    input  logic               fft_done,
    input  logic               rem_done,
    input  logic [1:0]         bank_free,
    output logic               dmrs_start,
    output logic               fft_start,
    output logic               rem_start,
    output logic               rem_is_dmrs,
    output logic               rem_bank,
    output logic               bank_valid,
    output logic [3:0]         sym_idx,
    output logic               busy,
    output logic               slot_done,
    output logic               err
);

    sched_state_t       state_reg, state_next;
    logic [3:0]         sym_idx_reg, sym_idx_next;
    logic [3:0]         sym_end_reg, sym_end_next;
    logic [NUM_SYM-1:0] dmrs_mask_reg, dmrs_mask_next;
    logic               rem_bank_reg, rem_bank_next;
    logic               rem_is_dmrs_reg, rem_is_dmrs_next;
    logic               busy_reg, busy_next;
    logic               dmrs_start_reg, dmrs_start_next;
    logic               fft_start_reg, fft_start_next;
    logic               rem_start_reg, rem_start_next;
    logic               bank_valid_reg, bank_valid_next;
    logic               slot_done_reg, slot_done_next;
    logic               err_reg, err_next;

    logic wd_enable, wd_expired;

    assign wd_enable = (state_reg == ST_DMRS_WAIT) || (state_reg == ST_DATA_WAIT) ||
                       (state_reg == ST_FFT_WAIT)  || (state_reg == ST_BANK_WAIT) ||
                       (state_reg == ST_REM_WAIT);

    pusch_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state_reg),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_next       = state_reg;
        sym_idx_next     = sym_idx_reg;
        sym_end_next     = sym_end_reg;
        dmrs_mask_next   = dmrs_mask_reg;
        rem_bank_next    = rem_bank_reg;
        rem_is_dmrs_next = rem_is_dmrs_reg;
        dmrs_start_next  = 1'b0;
        fft_start_next   = 1'b0;
        rem_start_next   = 1'b0;
        bank_valid_next  = 1'b0;
        slot_done_next   = 1'b0;
        err_next         = 1'b0;

        // Priority: abort, then watchdog, then the per-state handshakes.
        if (abort) begin
            state_next       = ST_IDLE;
            rem_is_dmrs_next = 1'b0;
        end else if (wd_expired) begin
            state_next       = ST_IDLE;
            rem_is_dmrs_next = 1'b0;
            err_next         = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_legal(sym_start, sym_end, n_rb)) begin
                            sym_idx_next    = sym_start;
                            sym_end_next    = sym_end;
                            dmrs_mask_next  = dmrs_mask;
                            rem_bank_next   = 1'b0;
                            dmrs_start_next = 1'b1;
                            state_next      = ST_DMRS_WAIT;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ST_DMRS_WAIT: begin
                    if (dmrs_done) state_next = ST_SYM_DECIDE;
                end
                ST_SYM_DECIDE: begin
                    // DMRS symbols bypass the data path and go straight to the mapper.
                    rem_is_dmrs_next = dmrs_mask_reg[sym_idx_reg];
                    state_next       = dmrs_mask_reg[sym_idx_reg] ? ST_BANK_WAIT : ST_DATA_WAIT;
                end
                ST_DATA_WAIT: begin
                    if (mod_done) begin
                        fft_start_next = 1'b1;
                        state_next     = ST_FFT_WAIT;
                    end
                end
                ST_FFT_WAIT: begin
                    if (fft_done) state_next = ST_BANK_WAIT;
                end
                ST_BANK_WAIT: begin
                    if (bank_free[rem_bank_reg]) begin
                        rem_start_next = 1'b1;
                        state_next     = ST_REM_WAIT;
                    end
                end
                ST_REM_WAIT: begin
                    if (rem_done) begin
                        bank_valid_next = 1'b1;
                        rem_bank_next   = ~rem_bank_reg;
                        if (sym_idx_reg == sym_end_reg) begin
                            state_next = ST_DONE;
                        end else begin
                            sym_idx_next = sym_idx_reg + 4'd1;
                            state_next   = ST_SYM_DECIDE;
                        end
                    end
                end
                ST_DONE: begin
                    slot_done_next   = 1'b1;
                    rem_is_dmrs_next = 1'b0;
                    state_next       = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            sym_idx_reg     <= '0;
            sym_end_reg     <= '0;
            dmrs_mask_reg   <= '0;
            rem_bank_reg    <= 1'b0;
            rem_is_dmrs_reg <= 1'b0;
            busy_reg        <= 1'b0;
            dmrs_start_reg  <= 1'b0;
            fft_start_reg   <= 1'b0;
            rem_start_reg   <= 1'b0;
            bank_valid_reg  <= 1'b0;
            slot_done_reg   <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sym_idx_reg     <= sym_idx_next;
            sym_end_reg     <= sym_end_next;
            dmrs_mask_reg   <= dmrs_mask_next;
            rem_bank_reg    <= rem_bank_next;
            rem_is_dmrs_reg <= rem_is_dmrs_next;
            busy_reg        <= busy_next;
            dmrs_start_reg  <= dmrs_start_next;
            fft_start_reg   <= fft_start_next;
            rem_start_reg   <= rem_start_next;
            bank_valid_reg  <= bank_valid_next;
            slot_done_reg   <= slot_done_next;
            err_reg         <= err_next;
        end
    end

    assign dmrs_start  = dmrs_start_reg;
    assign fft_start   = fft_start_reg;
    assign rem_start   = rem_start_reg;
    assign rem_is_dmrs = rem_is_dmrs_reg;
    assign rem_bank    = rem_bank_reg;
    assign bank_valid  = bank_valid_reg;
    assign sym_idx     = sym_idx_reg;
    assign busy        = busy_reg;
    assign slot_done   = slot_done_reg;
    assign err         = err_reg;

endmodule
